mem_sequencer: RTL

//  Parametrised byte-serial load/store sequencer between a CPU core and the byte-wide SoC block RAM.

---
 rtl/mem_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// Byte-serial big-endian load/store sequencer between a CPU core and a byte-wide block RAM.
// Define MISALIGN_TRAP_EN to reject misaligned accesses with err instead of performing them.
module mem_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_BYTES = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [1:0]              size,
  input  logic                    signext,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  output logic [8*WORD_BYTES-1:0] rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [7:0]              mem_data_out,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [7:0]              mem_data_in,
  output logic                    mem_write
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + RD_LATENCY + 1);
  localparam logic [1:0] MAX_SIZE = 2'($clog2(WORD_BYTES));

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_next;

  logic [3:0]            req_n, n_r;
  logic [1:0]            size_c;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [W-1:0]          wbuf, wshift, shreg, sh_next, ext;
  logic                  signext_r, sign;
  logic                  accept, issue, capture, write_byte, finish;
  logic                  trap_now, trap_r;

  assign size_c = (size > MAX_SIZE) ? MAX_SIZE : size;
  assign req_n  = 4'd1 << size_c;
  // Left-justify the n store bytes so each write cycle just takes the top byte.
  assign wshift = wdata << (8 * (WORD_BYTES - int'(req_n)));

`ifdef MISALIGN_TRAP_EN
  assign trap_now = (addr & ADDR_WIDTH'(req_n - 4'd1)) != '0;
`else
  assign trap_now = 1'b0;
  assign trap_r   = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // cnt is the number of edges since acceptance; issue and capture both key off it.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    write_byte = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = we ? WRITE : READ;
        end
      end
      READ: begin
        if (trap_r) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          issue   = int'(cnt) < int'(n_r);
          capture = int'(cnt) >= RD_LATENCY;
          if (int'(cnt) == int'(n_r) + RD_LATENCY - 1) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WRITE: begin
        if (!trap_r && int'(cnt) < int'(n_r)) begin
          write_byte = 1'b1;
        end else begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sh_next = (shreg << 8) | W'(mem_data_out);
    sign    = 1'b0;
    for (int b = 0; b < WORD_BYTES; b++)
      if (b == int'(n_r) - 1) sign = sh_next[8*b+7];
    ext = sh_next;
    for (int b = 0; b < WORD_BYTES; b++)
      if (b >= int'(n_r)) ext[8*b +: 8] = {8{signext_r & sign}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      n_r         <= '0;
      cnt         <= '0;
      addr_r      <= '0;
      wbuf        <= '0;
      shreg       <= '0;
      signext_r   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_r      <= 1'b0;
      err         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      err  <= 1'b0;
`endif
      if (state != IDLE) cnt <= cnt + CW'(1);
      if (accept) begin
        busy      <= 1'b1;
        n_r       <= req_n;
        addr_r    <= addr;
        signext_r <= signext;
        shreg     <= '0;
        cnt       <= CW'(1);
`ifdef MISALIGN_TRAP_EN
        trap_r    <= trap_now;
`endif
        if (!trap_now) begin
          if (we) begin
            mem_waddr   <= addr;
            mem_data_in <= wshift[W-1 -: 8];
            mem_write   <= 1'b1;
            wbuf        <= wshift << 8;
          end else begin
            mem_raddr <= addr;
          end
        end
      end
      if (issue)   mem_raddr <= addr_r + ADDR_WIDTH'(cnt);
      if (capture) shreg <= sh_next;
      if (write_byte) begin
        mem_waddr   <= addr_r + ADDR_WIDTH'(cnt);
        mem_data_in <= wbuf[W-1 -: 8];
        wbuf        <= wbuf << 8;
        mem_write   <= 1'b1;
      end
      if (finish) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        mem_write <= 1'b0;
        if (state == READ && !trap_r) rdata <= ext;
`ifdef MISALIGN_TRAP_EN
        err       <= trap_r;
`endif
      end
    end
  end

endmodule
